// File: rtl/io_cond_bank.sv
// N-channel pad input conditioning: synchroniser, optional deglitch filter, edge pulses, status LEDs.
// Macro IO_COND_FILTER_EN enables the deglitch filter; otherwise o_filt is o_sync delayed one cycle.
module io_cond_bank #(
  parameter int unsigned     N_CH        = 4,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter int unsigned     FILT_LEN    = 4,
  parameter int unsigned     STRETCH_CYC = 16,
  parameter logic [N_CH-1:0] RST_VAL     = '0,
  parameter logic [N_CH-1:0] LED_MODE    = '0,
  parameter logic [N_CH-1:0] LED_INV     = '0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_pad,
  output logic [N_CH-1:0] o_sync,
  output logic [N_CH-1:0] o_filt,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_led
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // Only the pad-facing stage is packed into the IOB.
    (* IOB = "TRUE" *) logic   sync_first_q;
    logic [SYNC_STAGES-2:0]    sync_rest_q;
    logic                      sync_lvl;
    logic                      filt_q, filt_d;
    logic                      rise_q, fall_q;
    logic                      led_q, led_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sync_first_q <= RST_VAL[g];
        sync_rest_q  <= {(SYNC_STAGES-1){RST_VAL[g]}};
      end else begin
        sync_first_q   <= i_pad[g];
        sync_rest_q[0] <= sync_first_q;
        for (int k = 1; k < SYNC_STAGES - 1; k++) begin
          sync_rest_q[k] <= sync_rest_q[k-1];
        end
      end
    end

    assign sync_lvl = sync_rest_q[SYNC_STAGES-2];

`ifdef IO_COND_FILTER_EN
    localparam int unsigned CW = $clog2(FILT_LEN + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Any matching cycle restarts the count, so only FILT_LEN consecutive mismatches flip o_filt.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_lvl != filt_q) begin
        if (cnt_q == CW'(FILT_LEN - 1)) begin
          filt_d = ~filt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end
`else
    assign filt_d = sync_lvl;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        filt_q <= RST_VAL[g];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        led_q  <= (LED_MODE[g] ? 1'b0 : RST_VAL[g]) ^ LED_INV[g];
      end else begin
        filt_q <= filt_d;
        rise_q <= filt_d & ~filt_q;
        fall_q <= ~filt_d & filt_q;
        led_q  <= led_d;
      end
    end

    if (LED_MODE[g]) begin : g_act
      localparam int unsigned SW = $clog2(STRETCH_CYC + 1);
      logic [SW-1:0] str_q, str_d;

      // LED follows the next counter value so it lights on the same edge the counter loads.
      always_comb begin
        str_d = str_q;
        if (rise_q || fall_q)  str_d = SW'(STRETCH_CYC);
        else if (str_q != '0)  str_d = str_q - 1'b1;
        led_d = (str_d != '0) ^ LED_INV[g];
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) str_q <= '0;
        else          str_q <= str_d;
      end
    end else begin : g_lvl
      assign led_d = filt_q ^ LED_INV[g];
    end

    assign o_sync[g] = sync_lvl;
    assign o_filt[g] = filt_q;
    assign o_rise[g] = rise_q;
    assign o_fall[g] = fall_q;
    assign o_led[g]  = led_q;
  end

endmodule
